// File: rtl/ac97_link_scheduler.sv
// AC97 link scheduler: builds and serializes 256-bit frames on sync/sdata_out,
// arbitrates the register-command channel (slots 1/2) between two requesters
// round-robin, and pulls stereo PCM (slots 3/4) through a valid/ready handshake.
// Optional macro AC97_READBACK_EN adds capture of codec register read data
// (rd_valid/rd_addr/rd_data) from sdata_in.
module ac97_link_scheduler #(
  parameter int unsigned PCM_W     = 20,
  parameter int unsigned SYNC_BITS = 16,
  parameter int unsigned UF_W      = 16
) (
  input  logic             raw_bit_clk,
  input  logic             reset_b,
  input  logic             codec_ready,
  input  logic [1:0]       cmd_req,
  input  logic [1:0]       cmd_rd,
  input  logic [13:0]      cmd_addr,
  input  logic [31:0]      cmd_data,
  output logic [1:0]       cmd_ack,
  input  logic             pcm_valid,
  input  logic [PCM_W-1:0] pcm_left,
  input  logic [PCM_W-1:0] pcm_right,
  output logic             pcm_ready,
  output logic             sync,
  output logic             sdata_out,
  input  logic             sdata_in,
  output logic             frame_start,
  output logic [UF_W-1:0]  underflow_cnt
`ifdef AC97_READBACK_EN
  ,
  output logic             rd_valid,
  output logic [6:0]       rd_addr,
  output logic [15:0]      rd_data
`endif
);

  logic [7:0]      k_q, k_d;
  logic            load;
  logic [255:0]    shift_q, shift_d;
  logic            sdata_q, sdata_d;
  logic            sync_q, sync_d;
  logic            fs_q, fs_d;
  logic [1:0]      ack_q, ack_d;
  logic            ready_q, ready_d;
  logic            ptr_q, ptr_d;
  logic [UF_W-1:0] uf_q, uf_d;

  logic [1:0]      grant;
  logic            gnt_idx;
  logic            have_cmd;
  logic            sel_rd;
  logic [6:0]      sel_addr;
  logic [15:0]     sel_data;
  logic [15:0]     tag;
  logic [19:0]     slot1, slot2, left20, right20;
  logic [255:0]    frame_new;

  // Frame load happens on the edge where the bit index wraps 255 -> 0.
  assign load = (k_q == 8'hFF);
  assign k_d  = k_q + 8'd1;

  // Round-robin grant: the pointer only breaks ties when both are requesting.
  always_comb begin
    if (cmd_req == 2'b11) begin
      grant = ptr_q ? 2'b10 : 2'b01;
    end else begin
      grant = cmd_req;
    end
    gnt_idx  = grant[1];
    have_cmd = |cmd_req;
    sel_rd   = cmd_rd[gnt_idx];
    sel_addr = gnt_idx ? cmd_addr[13:7] : cmd_addr[6:0];
    sel_data = gnt_idx ? cmd_data[31:16] : cmd_data[15:0];
  end

  // Assemble the next frame image; a codec that is not ready gets all zeros.
  always_comb begin
    left20  = '0;
    right20 = '0;
    if (pcm_valid) begin
      // Narrow samples are MSB-aligned with zero fill below.
      left20[19 -: PCM_W]  = pcm_left;
      right20[19 -: PCM_W] = pcm_right;
    end
    tag       = {1'b1, have_cmd, have_cmd & ~sel_rd, pcm_valid, pcm_valid, 11'b0};
    slot1     = have_cmd ? {sel_rd, sel_addr, 12'b0} : 20'b0;
    slot2     = (have_cmd && !sel_rd) ? {sel_data, 4'b0} : 20'b0;
    frame_new = '0;
    if (codec_ready) begin
      frame_new = {tag, slot1, slot2, left20, right20, 160'b0};
    end
  end

  // Next state: shift out the frame, and on load latch a new frame and handshakes.
  always_comb begin
    sync_d  = (32'(k_d) < SYNC_BITS);
    shift_d = {shift_q[254:0], 1'b0};
    sdata_d = shift_q[255];
    fs_d    = 1'b0;
    ack_d   = 2'b00;
    ready_d = 1'b0;
    ptr_d   = ptr_q;
    uf_d    = uf_q;
    if (load) begin
      shift_d = {frame_new[254:0], 1'b0};
      sdata_d = frame_new[255];
      fs_d    = 1'b1;
      if (codec_ready) begin
        ack_d   = grant;
        ready_d = pcm_valid;
        if (have_cmd) begin
          ptr_d = ~gnt_idx;
        end
        if (!pcm_valid && (uf_q != '1)) begin
          uf_d = uf_q + UF_W'(1);
        end
      end
    end
  end

  // State registers; reset abandons any partial frame and restarts at bit 0.
  always_ff @(posedge raw_bit_clk or negedge reset_b) begin
    if (!reset_b) begin
      k_q     <= 8'hFF;
      shift_q <= '0;
      sdata_q <= 1'b0;
      sync_q  <= 1'b0;
      fs_q    <= 1'b0;
      ack_q   <= 2'b00;
      ready_q <= 1'b0;
      ptr_q   <= 1'b0;
      uf_q    <= '0;
    end else begin
      k_q     <= k_d;
      shift_q <= shift_d;
      sdata_q <= sdata_d;
      sync_q  <= sync_d;
      fs_q    <= fs_d;
      ack_q   <= ack_d;
      ready_q <= ready_d;
      ptr_q   <= ptr_d;
      uf_q    <= uf_d;
    end
  end

  assign sync          = sync_q;
  assign sdata_out     = sdata_q;
  assign frame_start   = fs_q;
  assign cmd_ack       = ack_q;
  assign pcm_ready     = ready_q;
  assign underflow_cnt = uf_q;

`ifdef AC97_READBACK_EN
  // Incoming bits 0..55 cover tag, slot 1 and slot 2; bit j lands at in_sr[55-j].
  logic [55:0] in_sr_q, in_sr_d;
  logic        rd_valid_q, rd_valid_d;
  logic [6:0]  rd_addr_q, rd_addr_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        unused_in_sr;

  assign unused_in_sr = ^{in_sr_q[52:39], in_sr_q[31:20], in_sr_q[3:0]};

  // Capture incoming slots and publish a read result at k=57 when tagged valid.
  always_comb begin
    in_sr_d    = in_sr_q;
    rd_valid_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    if (k_q <= 8'd55) begin
      in_sr_d = {in_sr_q[54:0], sdata_in};
    end
    if ((k_q == 8'd56) && (&in_sr_q[55:53])) begin
      rd_valid_d = 1'b1;
      rd_addr_d  = in_sr_q[38:32];
      rd_data_d  = in_sr_q[19:4];
    end
  end

  // Readback registers.
  always_ff @(posedge raw_bit_clk or negedge reset_b) begin
    if (!reset_b) begin
      in_sr_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      in_sr_q    <= in_sr_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;
`else
  logic unused_sdata_in;
  assign unused_sdata_in = sdata_in;
`endif

endmodule

// File: tb/tb_ac97_link_scheduler.sv
// Bench for ac97_link_scheduler: scenario tasks with inline checks against a
// frame-level reference model (slot table, round-robin by scan order).
module tb_ac97_link_scheduler;
  localparam int unsigned PCM_W = 20;

  logic             raw_bit_clk = 1'b0;
  logic             reset_b = 1'b0;
  logic             codec_ready = 1'b0;
  logic [1:0]       cmd_req = '0;
  logic [1:0]       cmd_rd = '0;
  logic [13:0]      cmd_addr = '0;
  logic [31:0]      cmd_data = '0;
  logic [1:0]       cmd_ack;
  logic             pcm_valid = 1'b0;
  logic [PCM_W-1:0] pcm_left = '0;
  logic [PCM_W-1:0] pcm_right = '0;
  logic             pcm_ready;
  logic             sync;
  logic             sdata_out;
  logic             sdata_in = 1'b0;
  logic             frame_start;
  logic [15:0]      underflow_cnt;
`ifdef AC97_READBACK_EN
  logic             rd_valid;
  logic [6:0]       rd_addr;
  logic [15:0]      rd_data;
`endif

  ac97_link_scheduler #(.PCM_W(PCM_W), .SYNC_BITS(16), .UF_W(16)) dut (
    .raw_bit_clk  (raw_bit_clk),
    .reset_b      (reset_b),
    .codec_ready  (codec_ready),
    .cmd_req      (cmd_req),
    .cmd_rd       (cmd_rd),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cmd_ack      (cmd_ack),
    .pcm_valid    (pcm_valid),
    .pcm_left     (pcm_left),
    .pcm_right    (pcm_right),
    .pcm_ready    (pcm_ready),
    .sync         (sync),
    .sdata_out    (sdata_out),
    .sdata_in     (sdata_in),
    .frame_start  (frame_start),
    .underflow_cnt(underflow_cnt)
`ifdef AC97_READBACK_EN
    ,
    .rd_valid     (rd_valid),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
`endif
  );

  always #5 raw_bit_clk = ~raw_bit_clk;

  int checks = 0;
  int errors = 0;

  // Requester state (bench side) and reference model state.
  bit          pend [2];
  bit          p_rd [2];
  logic [6:0]  p_addr [2];
  logic [15:0] p_data [2];
  int          ptr_m = 0;
  logic [15:0] uf_m = '0;

  // Captured frame observations.
  logic [255:0] got, sync_got, exp_f, codec_in;
  logic [1:0]   ack0, exp_ack;
  logic         rdy0, exp_rdy;
  int           extra, waitc, rd_hits, rd_idx;
  logic [6:0]   rd_a;
  logic [15:0]  rd_d;

  task automatic drive_cmd();
    cmd_req  = {pend[1], pend[0]};
    cmd_rd   = {p_rd[1], p_rd[0]};
    cmd_addr = {p_addr[1], p_addr[0]};
    cmd_data = {p_data[1], p_data[0]};
  endtask

  // Reference model: what the frame loaded from the current inputs must contain.
  task automatic model_load();
    logic [19:0] slot [1:12];
    logic [15:0] tag;
    int g;
    exp_f = '0;
    exp_ack = 2'b00;
    exp_rdy = 1'b0;
    if (codec_ready) begin
      for (int n = 1; n <= 12; n++) slot[n] = '0;
      tag = 16'h8000;
      g = -1;
      for (int i = 0; i < 2; i++) begin
        if (g < 0 && pend[(ptr_m + i) % 2]) g = (ptr_m + i) % 2;
      end
      if (g >= 0) begin
        tag[14] = 1'b1;
        tag[13] = !p_rd[g];
        slot[1] = {p_rd[g], p_addr[g], 12'b0};
        if (!p_rd[g]) slot[2] = {p_data[g], 4'b0};
        exp_ack[g] = 1'b1;
        ptr_m = (g == 0) ? 1 : 0;
      end
      if (pcm_valid) begin
        tag[12] = 1'b1;
        tag[11] = 1'b1;
        slot[3] = 20'(pcm_left) << (20 - PCM_W);
        slot[4] = 20'(pcm_right) << (20 - PCM_W);
        exp_rdy = 1'b1;
      end else if (uf_m != 16'hFFFF) begin
        uf_m = uf_m + 16'd1;
      end
      exp_f[255 -: 16] = tag;
      for (int n = 1; n <= 12; n++) exp_f[239 - 20 * (n - 1) -: 20] = slot[n];
    end
  endtask

  // Wait (bounded) for frame_start and record one whole frame; scrambles
  // sampled inputs mid-frame to show they are only sampled at load.
  task automatic capture();
    logic s_rdy, s_pv;
    logic [PCM_W-1:0] s_l, s_r;
    waitc = 0; extra = 0; rd_hits = 0; rd_idx = -1;
    ack0 = '0; rdy0 = 1'b0; got = '0; sync_got = '0;
    @(negedge raw_bit_clk);
    while (frame_start !== 1'b1 && waitc < 300) begin
      waitc++;
      @(negedge raw_bit_clk);
    end
    if (frame_start === 1'b1) begin
      s_rdy = codec_ready; s_pv = pcm_valid; s_l = pcm_left; s_r = pcm_right;
      for (int i = 0; i < 256; i++) begin
        got[255 - i] = sdata_out;
        sync_got[255 - i] = sync;
        if (i == 0) begin
          ack0 = cmd_ack;
          rdy0 = pcm_ready;
        end else if (cmd_ack !== 2'b00 || pcm_ready !== 1'b0 || frame_start !== 1'b0) begin
          extra++;
        end
`ifdef AC97_READBACK_EN
        if (rd_valid === 1'b1) begin
          rd_hits++; rd_idx = i; rd_a = rd_addr; rd_d = rd_data;
        end
`endif
        sdata_in = codec_in[255 - i];
        if (i == 128) begin
          codec_ready = ~codec_ready; pcm_valid = ~pcm_valid;
          pcm_left = PCM_W'($urandom); pcm_right = PCM_W'($urandom);
        end
        if (i == 250) begin
          codec_ready = s_rdy; pcm_valid = s_pv; pcm_left = s_l; pcm_right = s_r;
        end
        if (i < 255) @(negedge raw_bit_clk);
      end
    end
  endtask

  task automatic test_reset();
    reset_b = 1'b0; codec_ready = 1'b1; pcm_valid = 1'b0; codec_in = '0;
    for (int r = 0; r < 2; r++) begin
      pend[r] = 0; p_rd[r] = 0; p_addr[r] = '0; p_data[r] = '0;
    end
    drive_cmd();
    repeat (3) @(negedge raw_bit_clk);
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b expected 0", sync); end
    checks++; if (sdata_out !== 1'b0) begin errors++; $display("FAIL reset_sdata: got %b expected 0", sdata_out); end
    checks++; if (cmd_ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b expected 00", cmd_ack); end
    checks++; if (pcm_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", pcm_ready); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
    checks++; if (underflow_cnt !== 16'd0) begin errors++; $display("FAIL reset_uf: got %h expected 0", underflow_cnt); end
    ptr_m = 0; uf_m = '0;
    reset_b = 1'b1;
  endtask

  task automatic test_idle();
    for (int f = 0; f < 3; f++) begin
      model_load();
      capture();
      checks++; if (waitc !== 0) begin errors++; $display("FAIL idle_period: waited %0d expected 0", waitc); end
      checks++; if (got[255:240] !== 16'h8000) begin errors++; $display("FAIL idle_tag: got %h expected 8000", got[255:240]); end
      checks++; if (got !== exp_f) begin errors++; $display("FAIL idle_frame: got %h expected %h", got, exp_f); end
      checks++; if (sync_got !== {16'hFFFF, 240'b0}) begin errors++; $display("FAIL idle_sync: got %h", sync_got); end
      checks++; if (underflow_cnt !== 16'(f + 1)) begin errors++; $display("FAIL idle_uf: got %0d expected %0d", underflow_cnt, f + 1); end
      checks++; if (extra !== 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", extra); end
    end
  endtask

  task automatic test_cmd_pcm();
    pend[0] = 1; p_rd[0] = 0; p_addr[0] = 7'h02; p_data[0] = 16'h0808;
    drive_cmd();
    pcm_valid = 1'b1; pcm_left = 20'h12345; pcm_right = 20'hFEDCB;
    model_load();
    capture();
    pend[0] = 0; drive_cmd(); pcm_valid = 1'b0;
    checks++; if (got[255:240] !== 16'hF800) begin errors++; $display("FAIL cp_tag: got %h expected F800", got[255:240]); end
    checks++; if (got[239:220] !== 20'h02000) begin errors++; $display("FAIL cp_slot1: got %h expected 02000", got[239:220]); end
    checks++; if (got[219:200] !== 20'h08080) begin errors++; $display("FAIL cp_slot2: got %h expected 08080", got[219:200]); end
    checks++; if (got[199:180] !== 20'h12345) begin errors++; $display("FAIL cp_slot3: got %h expected 12345", got[199:180]); end
    checks++; if (got[179:160] !== 20'hFEDCB) begin errors++; $display("FAIL cp_slot4: got %h expected FEDCB", got[179:160]); end
    checks++; if (got !== exp_f) begin errors++; $display("FAIL cp_frame: got %h expected %h", got, exp_f); end
    checks++; if (ack0 !== 2'b01) begin errors++; $display("FAIL cp_ack: got %b expected 01", ack0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL cp_ready: got %b expected 1", rdy0); end
    checks++; if (underflow_cnt !== uf_m) begin errors++; $display("FAIL cp_uf: got %0d expected %0d", underflow_cnt, uf_m); end
  endtask

  task automatic test_not_ready();
    logic [15:0] uf_before;
    uf_before = uf_m;
    pend[0] = 1; p_rd[0] = 0; p_addr[0] = 7'h26; p_data[0] = 16'hABCD;
    drive_cmd();
    codec_ready = 1'b0; pcm_valid = 1'b1; pcm_left = 20'h0F0F0; pcm_right = 20'h33333;
    for (int f = 0; f < 2; f++) begin
      model_load();
      capture();
      checks++; if (got !== 256'b0) begin errors++; $display("FAIL nr_frame: got %h expected 0", got); end
      checks++; if (ack0 !== 2'b00 || rdy0 !== 1'b0) begin errors++; $display("FAIL nr_handshake: ack %b ready %b expected 00 0", ack0, rdy0); end
      checks++; if (underflow_cnt !== uf_before) begin errors++; $display("FAIL nr_uf: got %0d expected %0d", underflow_cnt, uf_before); end
    end
    codec_ready = 1'b1;
    model_load();
    capture();
    pend[0] = 0; drive_cmd(); pcm_valid = 1'b0;
    checks++; if (ack0 !== 2'b01) begin errors++; $display("FAIL nr_resume_ack: got %b expected 01", ack0); end
    checks++; if (got[239:220] !== 20'h26000) begin errors++; $display("FAIL nr_resume_slot1: got %h expected 26000", got[239:220]); end
    checks++; if (got !== exp_f) begin errors++; $display("FAIL nr_resume_frame: got %h expected %h", got, exp_f); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          pend[r] = 1; p_rd[r] = 1'($urandom_range(0, 1));
          p_addr[r] = 7'($urandom); p_data[r] = 16'($urandom);
        end
      end
      drive_cmd();
      codec_ready = ($urandom_range(0, 9) != 0);
      pcm_valid = 1'($urandom_range(0, 1));
      pcm_left = PCM_W'($urandom); pcm_right = PCM_W'($urandom);
      model_load();
      capture();
      for (int r = 0; r < 2; r++) if (exp_ack[r]) pend[r] = 0;
      checks++; if (waitc !== 0) begin errors++; $display("FAIL rnd_period: waited %0d expected 0", waitc); end
      checks++; if (got !== exp_f) begin errors++; $display("FAIL rnd_frame %0d: got %h expected %h", f, got, exp_f); end
      checks++; if (ack0 !== exp_ack) begin errors++; $display("FAIL rnd_ack %0d: got %b expected %b", f, ack0, exp_ack); end
      checks++; if (rdy0 !== exp_rdy) begin errors++; $display("FAIL rnd_ready %0d: got %b expected %b", f, rdy0, exp_rdy); end
      checks++; if (underflow_cnt !== uf_m) begin errors++; $display("FAIL rnd_uf %0d: got %0d expected %0d", f, underflow_cnt, uf_m); end
      checks++; if (extra !== 0) begin errors++; $display("FAIL rnd_pulses %0d: got %0d expected 0", f, extra); end
    end
    pend[0] = 0; pend[1] = 0; drive_cmd(); codec_ready = 1'b1; pcm_valid = 1'b0;
  endtask

  task automatic test_midframe_reset();
    int w;
    pend[0] = 1; p_rd[0] = 0; p_addr[0] = 7'h05; p_data[0] = 16'h5555;
    drive_cmd();
    codec_ready = 1'b1; pcm_valid = 1'b0;
    model_load();
    w = 0;
    @(negedge raw_bit_clk);
    while (frame_start !== 1'b1 && w < 300) begin
      w++;
      @(negedge raw_bit_clk);
    end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL mr_frame_start: got %b expected 1", frame_start); end
    pend[0] = 0; drive_cmd();
    repeat (100) @(negedge raw_bit_clk);
    reset_b = 1'b0;
    #1;
    checks++; if (sync !== 1'b0 || sdata_out !== 1'b0) begin errors++; $display("FAIL mr_outputs: sync %b sdata %b expected 0 0", sync, sdata_out); end
    checks++; if (underflow_cnt !== 16'd0) begin errors++; $display("FAIL mr_uf: got %0d expected 0", underflow_cnt); end
    ptr_m = 0; uf_m = '0;
    pend[0] = 1; p_rd[0] = 0; p_addr[0] = 7'h11; p_data[0] = 16'h1234;
    pend[1] = 1; p_rd[1] = 1; p_addr[1] = 7'h7C; p_data[1] = 16'hDEAD;
    drive_cmd();
    repeat (2) @(negedge raw_bit_clk);
    reset_b = 1'b1;
  endtask

  task automatic test_round_robin();
    for (int f = 0; f < 4; f++) begin
      model_load();
      capture();
      checks++; if (waitc !== 0) begin errors++; $display("FAIL rr_period %0d: waited %0d expected 0", f, waitc); end
      checks++; if (ack0 !== ((f % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_grant %0d: got %b", f, ack0); end
      checks++; if (got !== exp_f) begin errors++; $display("FAIL rr_frame %0d: got %h expected %h", f, got, exp_f); end
      checks++; if (underflow_cnt !== uf_m) begin errors++; $display("FAIL rr_uf %0d: got %0d expected %0d", f, underflow_cnt, uf_m); end
      if (f % 2 == 1) begin
        checks++; if (got[239:220] !== 20'hFC000 || got[253] !== 1'b0) begin errors++; $display("FAIL rr_read %0d: slot1 %h tag13 %b expected FC000 0", f, got[239:220], got[253]); end
      end
    end
    pend[0] = 0; pend[1] = 0; drive_cmd();
  endtask

`ifdef AC97_READBACK_EN
  task automatic test_readback();
    codec_in = {16'hE000, 20'h7C000, 20'h4E530, 200'b0};
    model_load();
    capture();
    codec_in = '0;
    checks++; if (rd_hits !== 1 || rd_idx !== 57) begin errors++; $display("FAIL rb_pulse: hits %0d at %0d expected 1 at 57", rd_hits, rd_idx); end
    checks++; if (rd_a !== 7'h7C) begin errors++; $display("FAIL rb_addr: got %h expected 7C", rd_a); end
    checks++; if (rd_d !== 16'h4E53) begin errors++; $display("FAIL rb_data: got %h expected 4E53", rd_d); end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_cmd_pcm();
    test_not_ready();
    test_random();
    test_midframe_reset();
    test_round_robin();
`ifdef AC97_READBACK_EN
    test_readback();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ac97_link_scheduler.md
Name: ac97_link_scheduler

Overview:
- Controller side of the AC97 serial link. Builds and serializes each 256-bit frame on sync/sdata_out.
- Arbitrates the single register-command channel (slots 1/2) between two requesters.
- Pulls stereo PCM samples (slots 3/4) through a valid/ready handshake.
- Sits between the audio MMIO/CPU logic and the codec pins, in the raw_bit_clk domain.

Parameters:
- PCM_W, 20, PCM sample width per channel; samples narrower than 20 are MSB-aligned, low bits zero-filled.
- SYNC_BITS, 16, number of bit clocks sync is held high at frame start.
- UF_W, 16, width of the PCM underflow counter.

Ports:
- raw_bit_clk  in  1  bit clock (12.288 MHz); all logic on rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- codec_ready  in  1  codec reports ready; gates the frame-valid tag.
- cmd_req  in  2  per-requester command request (bit0 = init sequencer, bit1 = CPU).
- cmd_rd  in  2  per-requester read(1)/write(0).
- cmd_addr  in  14  {req1[6:0], req0[6:0]} register address.
- cmd_data  in  32  {req1[15:0], req0[15:0]} write data.
- cmd_ack  out  2  one-cycle pulse when that requester's command is loaded into a frame.
- pcm_valid  in  1  stereo sample available.
- pcm_left  in  PCM_W  left sample.
- pcm_right  in  PCM_W  right sample.
- pcm_ready  out  1  one-cycle pulse when the sample is consumed.
- sync  out  1  AC97 SYNC.
- sdata_out  out  1  serial frame data, MSB first.
- sdata_in  in  1  codec serial data (used only with the optional feature).
- frame_start  out  1  one-cycle pulse at frame bit 0.
- underflow_cnt  out  UF_W  count of frames sent with no PCM; saturating.

Behaviour:
- Bit index k, 8-bit, wraps 255 to 0. After reset k=255, so the first edge after release starts frame bit 0.
- Reset values: sync=0, sdata_out=0, cmd_ack=0, pcm_ready=0, frame_start=0, underflow_cnt=0, round-robin pointer=req0.
- Frame load happens on the edge where k goes 255 to 0:
  - Latch codec_ready, the command, and the PCM sample.
  - Assert frame_start for that cycle.
- Registered outputs for the cycle at index k: sync=(k<SYNC_BITS); sdata_out=frame[255-k].
- Frame layout, MSB first:
  - Slot 0 tag (16 bits): [15] frame valid, [14] slot 1 valid, [13] slot 2 valid, [12] slot 3 valid, [11] slot 4 valid, rest 0.
  - Slots 1–12: 20 bits each.
  - Slot 1: {rd, addr[6:0], 12'b0}.
  - Slot 2: {data[15:0], 4'b0}; all zeros for a read.
  - Slots 3/4: left/right samples.
  - Slots 5–12: zero.
- codec_ready=0 at load:
  - Whole frame is zero (tag bit 15 = 0).
  - No cmd_ack, no pcm_ready, underflow_cnt unchanged.
- Command arbitration, round-robin:
  - If both requesters are requesting, grant the requester the pointer indicates, then point at the other one.
  - If only one is requesting, grant it; the pointer still moves past it.
  - Granted command: tag[14]=1; tag[13]=1 only for a write; cmd_ack[g] pulses in the load cycle.
  - Requesters hold req, rd, addr and data stable until ack, and drop req the cycle after ack.
  - No request: tag[14]=tag[13]=0, slots 1/2 zero.
- PCM:
  - pcm_valid=1 at load: tag[12]=tag[11]=1, sample latched, pcm_ready pulses.
  - pcm_valid=0 at load: tag[12:11]=0, slots 3/4 zero, underflow_cnt+1, saturating at all-ones.
- Inputs are sampled only at load; changes mid-frame never affect the frame in flight.
- reset_b asserted mid-frame:
  - Outputs go to reset values immediately (asynchronously).
  - The partial frame is abandoned; the in-flight command counts as acked and is not replayed.

Optional Feature:
- AC97_READBACK_EN. When defined, adds the following:
  - Output rd_valid (1 bit).
  - Output rd_addr (7 bits).
  - Output rd_data (16 bits).
- sdata_in is sampled on the rising edge; incoming frame bit j is captured at k=j+1.
- At k=57 of a frame whose incoming tag has bits 15, 14 and 13 all set:
  - rd_addr = incoming slot 1 bits [18:12].
  - rd_data = incoming slot 2 bits [19:4].
  - rd_valid pulses for one cycle.
- Undefined: these ports are absent, sdata_in is ignored, and no capture logic is built.

Test Plan:
- Reset release with codec_ready=1, no requests, pcm_valid=0:
  - sync high exactly 16 cycles every 256 cycles; frame_start every 256 cycles.
  - Tag = 0x8000; underflow_cnt increments 1 per frame.
- req0 write addr 0x02 data 0x0808, same frame as pcm_valid with left=0x12345, right=0xFEDCB:
  - Tag = 0xF800.
  - Slot 1 = 0x02000, slot 2 = 0x08080, slot 3 = 0x12345, slot 4 = 0xFEDCB.
  - cmd_ack[0] and pcm_ready pulse at load.
- Both requesters held continuously:
  - Grants alternate 0,1,0,1 over four frames.
  - Read from req1 at addr 0x7C gives slot 1 = 0xFC000, tag[13]=0.
- codec_ready=0 with pending req0 and pcm_valid:
  - 256 zero bits per frame; no ack, no ready, underflow_cnt unchanged.
  - The frame after codec_ready rises carries the command.
- reset_b pulsed low at k=100:
  - sync and sdata_out go to 0 immediately.
  - After release the next frame starts at k=0 with pointer=req0.
- With AC97_READBACK_EN: codec returns tag 0xE000, slot 1 0x7C000, slot 2 0x4E530:
  - rd_valid pulses at k=57 with rd_addr=0x7C, rd_data=0x4E53.
